// File: rtl/store_write_buffer.sv
// store_write_buffer: store side of the data-memory interface.
// Aligns SB/SH/SW requests into word address, lane-replicated data and byte
// strobes, queues them in a DEPTH-entry FIFO, and drains the head entry to
// memory over a valid/ready handshake.
// Optional feature macro: STORE_MISALIGN_TRAP_EN (drop misaligned SH/SW and
// pulse store_err). The default build ignores misaligned low address bits.
module store_write_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_data,
    input  logic [2:0]    req_funct3,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          store_err,
    output logic          busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } entry_t;

    entry_t        buf_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          store_err_q;

    entry_t        new_entry;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;

    // Decode funct3 into an aligned entry and decide whether it may be queued.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        new_entry.addr  = {req_addr[AW-1:2], 2'b00};
        new_entry.wdata = '0;
        new_entry.wstrb = '0;
        legal           = 1'b0;
        case (req_funct3)
            F3_SB: begin
                legal           = 1'b1;
                new_entry.wstrb = 4'b0001 << req_addr[1:0];
                new_entry.wdata = {4{req_data[7:0]}};
            end
            F3_SH: begin
`ifdef STORE_MISALIGN_TRAP_EN
                legal           = ~req_addr[0];
`else
                legal           = 1'b1;
`endif
                new_entry.wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                new_entry.wdata = {2{req_data[15:0]}};
            end
            F3_SW: begin
`ifdef STORE_MISALIGN_TRAP_EN
                legal           = (req_addr[1:0] == 2'b00);
`else
                legal           = 1'b1;
`endif
                new_entry.wstrb = 4'b1111;
                new_entry.wdata = req_data;
            end
            default: legal = 1'b0;
        endcase
    end

    // Ready and valid come straight from registered occupancy, so a pop does
    // not re-open req_ready until the following cycle.
    assign req_ready = (count_q != CW'(DEPTH));
    assign mem_valid = (count_q != '0);
    assign busy      = mem_valid;
    assign store_err = store_err_q;

    assign accept = req_valid && req_ready;
    assign push   = accept && legal;
    assign pop    = mem_valid && mem_ready;

    // Outputs are forced to zero while empty so reset drives them to 0 at once.
    assign mem_addr  = mem_valid ? buf_q[head_q].addr  : '0;
    assign mem_wdata = mem_valid ? buf_q[head_q].wdata : '0;
    assign mem_wstrb = mem_valid ? buf_q[head_q].wstrb : '0;

    // Pointer, occupancy and error-pulse state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            store_err_q <= 1'b0;
        end else begin
            store_err_q <= accept && !legal;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, written at the tail on a legal push.
    // NOTE: the storage array is deliberately not reset; occupancy gates every
    // read, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) buf_q[tail_q] <= new_entry;
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: a driver issues requests and
// queues expected memory writes / error pulses; a negedge monitor compares.
module tb_store_write_buffer;

    localparam int DEPTH = 2;
    localparam int AW    = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic [2:0]    req_funct3 = '0;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          store_err;
    logic          busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   rnd_mode = 0;
    exp_t exp_q[$];
    int   err_q[$];

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .store_err(store_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Legality from the access size: size in bytes is 1<<funct3.
    function automatic bit legal_req(input logic [31:0] a, input logic [2:0] f);
        if (f > 3'd2) return 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        if ((a % (32'd1 << f)) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Byte lane k carries data byte (k mod size); lanes of the size-aligned
    // group containing the address are enabled.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        exp_t e;
        int   n;
        n = 1 << f;
        e.addr  = a & ~32'd3;
        e.wdata = '0;
        e.wstrb = '0;
        for (int k = 0; k < 4; k++) begin
            e.wdata[8*k +: 8] = d[8*(k % n) +: 8];
            e.wstrb[k]        = ((k / n) == ((a % 4) / n));
        end
        return e;
    endfunction

    // Issue one request; hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int waited = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_data = d; req_funct3 = f;
        if (rnd_mode) mem_ready = 1'($urandom_range(0, 1));
        forever begin
            @(negedge clk);
            if (req_ready) begin
                if (legal_req(a, f)) exp_q.push_back(model(a, d, f));
                else                 err_q.push_back(cyc + 1);
                break;
            end
            waited++;
            if (waited > 60) begin
                check("accept_timeout", 64'd1, 64'd0);
                break;
            end
            @(posedge clk); #1;
            if (rnd_mode) mem_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_store_err"}, 64'(store_err), 64'd0);
        check({tag, "_mem_bus"},   {mem_addr, mem_wdata} ^ 64'(mem_wstrb), 64'd0);
    endtask

    // Monitor: occupancy model, handshake/error/stability checks.
    int          occ = 0;
    bit          stall = 0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;
    always @(negedge clk) begin
        if (!rst_n) begin
            occ   = 0;
            stall = 0;
        end else begin
            bit   exp_err;
            bit   do_push, do_pop;
            exp_t e;
            check("req_ready", 64'(req_ready), 64'(occ != DEPTH));
            check("mem_valid", 64'(mem_valid), 64'(occ != 0));
            check("busy",      64'(busy),      64'(occ != 0));
            exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
            check("store_err", 64'(store_err), 64'(exp_err));
            if (exp_err) void'(err_q.pop_front());
            if (stall && mem_valid) begin
                check("stall_addr",  64'(mem_addr),  64'(h_addr));
                check("stall_wdata", 64'(mem_wdata), 64'(h_wdata));
                check("stall_wstrb", 64'(mem_wstrb), 64'(h_wstrb));
            end
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_addr",  64'(mem_addr),  64'(e.addr));
                    check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    check("mem_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
                end
            end
            stall   = mem_valid && !mem_ready;
            h_addr  = mem_addr;
            h_wdata = mem_wdata;
            h_wstrb = mem_wstrb;
            do_push = req_valid && (occ != DEPTH) && legal_req(req_addr, req_funct3);
            do_pop  = (occ != 0) && mem_ready;
            occ     = occ + int'(do_push) - int'(do_pop);
        end
    end

    initial begin
        #1;
        reset_checks("reset");
        idle(2);
        rst_n = 1'b1;

        // 1: SB at byte 3
        mem_ready = 1'b1;
        send(32'h1003, 32'h0000_00AB, 3'b000);
        idle(2);
        // 2: SH upper half, SW aligned, SB/SH lower lanes
        send(32'h2002, 32'h0000_BEEF, 3'b001);
        send(32'h3000, 32'h1234_5678, 3'b010);
        send(32'h5001, 32'hCAFE_0012, 3'b000);
        send(32'h6000, 32'h0000_A55A, 3'b001);
        idle(3);

        // 3: fill while memory stalls, third request waits, then drain
        mem_ready = 1'b0;
        send(32'h7000, 32'h1111_1111, 3'b010);
        send(32'h7004, 32'h2222_2222, 3'b010);
        fork
            send(32'h7008, 32'h3333_3333, 3'b010);
            begin
                idle(4);
                mem_ready = 1'b1;
            end
        join
        idle(4);

        // 4: illegal funct3 values
        send(32'h8000, 32'hDEAD_BEEF, 3'b011);
        idle(2);
        send(32'h8004, 32'hDEAD_BEEF, 3'b111);
        idle(2);

        // 5: misaligned SW / SH
        send(32'h4001, 32'h0BAD_F00D, 3'b010);
        send(32'h4003, 32'h0000_1234, 3'b001);
        idle(3);

        // 6: reset with two entries queued, mid-handshake
        mem_ready = 1'b0;
        send(32'h9000, 32'hAAAA_0001, 3'b010);
        send(32'h9004, 32'hAAAA_0002, 3'b010);
        mem_ready = 1'b1;
        check("pre_reset_valid", 64'(mem_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        reset_checks("mid_reset");
        exp_q.delete();
        err_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        check("post_reset_busy",  64'(busy),      64'd0);
        check("post_reset_ready", 64'(req_ready), 64'd1);

        // Randomized traffic with random memory backpressure
        rnd_mode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            send($urandom, $urandom, f);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_mode  = 0;
        mem_ready = 1'b1;
        begin
            int budget = 0;
            while ((exp_q.size() != 0 || err_q.size() != 0) && budget < 100) begin
                idle(1);
                budget++;
            end
            if (budget >= 100) check("drain_timeout", 64'd1, 64'd0);
        end
        idle(3);
        check("final_idle", 64'(busy), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
